rotate_arbiter: RTL
===================

Name: rotate_arbiter

Overview:
- Shares one `rotate` CORDIC instance between two phase-tagged sample streams.
- Typical requesters: per-packet frequency correction and pilot-tracking phase correction.
- Arbitrates at packet granularity with round-robin fairness and feeds the CORDIC input.
- Routes each CORDIC output beat back to the requester that issued it, using an in-flight tag FIFO. Sits between the requesters and the CORDIC in the receive chain.

Parameters:
- DEPTH, 16: max beats in flight inside the CORDIC, i.e. tag FIFO entries. Power of two, >= 2, and >= CORDIC latency + output skid.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- s0_valid / s0_ready  in/out  1/1  requester 0 input handshake
- s0_data  in  64  requester 0 beat: {phase[31:0], iq[31:0]}
- s0_last  in  1  requester 0 end of packet
- s1_valid / s1_ready / s1_data / s1_last  in/out/in/in  1/1/64/1  requester 1, same layout
- c_valid / c_ready  out/in  1/1  CORDIC input handshake
- c_data  out  64  CORDIC input beat
- c_last  out  1  CORDIC input last
- r_valid / r_ready  in/out  1/1  CORDIC output handshake
- r_data  in  32  CORDIC output beat
- r_last  in  1  CORDIC output last
- m0_valid / m0_ready / m0_data / m0_last  out/in/out/out  1/1/32/1  requester 0 result
- m1_valid / m1_ready / m1_data / m1_last  out/in/out/out  1/1/32/1  requester 1 result
- err  out  1  sticky tag-underflow error (see Optional Feature)

Behaviour:
- Reset: synchronous, active-high, on clk.
  - State IDLE, round-robin priority = requester 0, tag FIFO empty, err = 0.
  - All valid and ready outputs 0 during reset and in the first cycle after.
- State machine: IDLE, BUSY0, BUSY1.
  - IDLE: if any sN_valid, register the grant. With both valid, pick the priority holder; otherwise pick the valid one. Go to BUSY<n> next cycle. No beat is forwarded in IDLE, giving a 1-cycle bubble per packet.
  - BUSYn: c_valid = sn_valid & !tag_full; c_data/c_last = sn_data/sn_last; sn_ready = c_ready & !tag_full; the other requester's ready = 0.
  - BUSYn, on an accepted beat with sn_last = 1: go to IDLE, priority := other requester.
  - Grant never changes mid-packet. The registered grant keeps c_data stable while c_valid is held.
- Tag FIFO:
  - Push grant id on each c_valid & c_ready.
  - Pop on each r_valid & r_ready.
  - Simultaneous push and pop: occupancy unchanged.
  - tag_full (occupancy == DEPTH) blocks issue and deasserts c_valid.
- Return path (combinational, no added latency):
  - head = FIFO head id.
  - m<head>_valid = r_valid & !tag_empty; m<other>_valid = 0.
  - m*_data / m*_last = r_data / r_last.
  - r_ready = m<head>_ready & !tag_empty.
  - Back-pressure from a stalled requester halts the CORDIC output for both requesters; this is accepted behaviour.
- In-order: result beats reach each requester in issue order.
- r_valid while tag FIFO empty: protocol violation. Data is dropped and r_ready = 0; err is set only with the optional feature.
- Reset mid-packet or with beats in flight: FIFO cleared and state returns to IDLE. The CORDIC shares the same reset and is flushed by it.

Optional Feature:
- Macro: ROTATE_ARBITER_ERR_EN.
- With the macro: err is set on any cycle with r_valid & tag_empty and holds until reset. An extra check also sets err if any requester's packet exceeds 65535 beats (16-bit beat counter per grant).
- Without the macro: err tied 0, no counter logic.

Test Plan:
- Requester 0 only, 4-beat packet (last on beat 3), CORDIC as 3-cycle pipeline, all ready = 1:
  - c_valid starts 1 cycle after s0_valid.
  - m0 receives 4 beats with last on beat 3; m1_valid stays 0.
- Both requesters valid at once with 2-beat packets, repeated 3 times:
  - Grants alternate 0,1,0,1,0,1.
  - No beat interleaving within a packet.
- DEPTH = 4, CORDIC r_ready held 0 via m0_ready = 0:
  - Exactly 4 beats issued, then c_valid = 0.
  - After m0_ready = 1, issue resumes and all beats are returned in order.
- Packets of requester 0 and requester 1 in flight back-to-back:
  - Each result beat goes to the requester matching its tag.
  - m1_ready = 0 stalls r_ready while m1 is at the FIFO head.
- Assert reset mid-packet with 2 beats in flight:
  - Next cycle all valids = 0, state IDLE, FIFO empty.
  - A new packet completes normally afterwards.
- With ROTATE_ARBITER_ERR_EN, inject r_valid = 1 with the FIFO empty:
  - err = 1 next cycle and stays 1 until reset.
  - No m*_valid is asserted.

Source files
------------

// File: rtl/rotate_arbiter.sv
// rotate_arbiter: shares one rotate CORDIC between two packetised requesters.
// Round-robin grant at packet granularity, in-flight tag FIFO routes each
// CORDIC result beat back to the requester that issued it.
// Optional build macro ROTATE_ARBITER_ERR_EN enables the sticky err flag
// (result beat with no tag in flight, or a packet longer than 65535 beats).
module rotate_arbiter #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s0_valid,
    output logic        s0_ready,
    input  logic [63:0] s0_data,
    input  logic        s0_last,
    input  logic        s1_valid,
    output logic        s1_ready,
    input  logic [63:0] s1_data,
    input  logic        s1_last,
    output logic        c_valid,
    input  logic        c_ready,
    output logic [63:0] c_data,
    output logic        c_last,
    input  logic        r_valid,
    output logic        r_ready,
    input  logic [31:0] r_data,
    input  logic        r_last,
    output logic        m0_valid,
    input  logic        m0_ready,
    output logic [31:0] m0_data,
    output logic        m0_last,
    output logic        m1_valid,
    input  logic        m1_ready,
    output logic [31:0] m1_data,
    output logic        m1_last,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY0,
        BUSY1
    } state_t;

    state_t         state;
    logic           prio;

    logic           tag_mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;

    logic           tag_full;
    logic           tag_empty;
    logic           head;
    logic           grant_id;
    logic           busy;
    logic           sel_valid;
    logic           push;
    logic           pop;

    assign tag_full  = (count == (AW+1)'(DEPTH));
    assign tag_empty = (count == '0);
    assign head      = tag_mem[rd_ptr];
    assign grant_id  = (state == BUSY1);
    assign busy      = (state != IDLE);
    assign sel_valid = grant_id ? s1_valid : s0_valid;

    // Issue side: the registered grant selects which requester feeds the
    // CORDIC; everything is gated off while reset is held.
    assign c_valid  = !reset && busy && sel_valid && !tag_full;
    assign c_data   = grant_id ? s1_data : s0_data;
    assign c_last   = grant_id ? s1_last : s0_last;
    assign s0_ready = !reset && (state == BUSY0) && c_ready && !tag_full;
    assign s1_ready = !reset && (state == BUSY1) && c_ready && !tag_full;

    // Return side: the tag at the FIFO head steers the result beat. A
    // stalled head requester stalls the whole CORDIC output.
    assign m0_valid = !reset && r_valid && !tag_empty && !head;
    assign m1_valid = !reset && r_valid && !tag_empty && head;
    assign m0_data  = r_data;
    assign m1_data  = r_data;
    assign m0_last  = r_last;
    assign m1_last  = r_last;
    assign r_ready  = !reset && !tag_empty && (head ? m1_ready : m0_ready);

    assign push = c_valid && c_ready;
    assign pop  = r_valid && r_ready;

    // Packet-level grant FSM: pick a requester in IDLE, hold it until its
    // last beat is accepted, then hand priority to the other side.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            prio  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s0_valid && s1_valid)
                        state <= prio ? BUSY1 : BUSY0;
                    else if (s0_valid)
                        state <= BUSY0;
                    else if (s1_valid)
                        state <= BUSY1;
                end
                BUSY0: begin
                    if (push && s0_last) begin
                        state <= IDLE;
                        prio  <= 1'b1;
                    end
                end
                BUSY1: begin
                    if (push && s1_last) begin
                        state <= IDLE;
                        prio  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag FIFO pointers and occupancy; a simultaneous push and pop leaves
    // the occupancy unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tag storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_ptr] <= grant_id;
    end

`ifdef ROTATE_ARBITER_ERR_EN
    logic [15:0] beat_cnt;
    logic        err_q;

    // Sticky error: orphan result beat, or a granted packet that runs past
    // 65535 beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (r_valid && tag_empty)
                err_q <= 1'b1;
            if (state == IDLE) begin
                beat_cnt <= '0;
            end else if (push) begin
                if (beat_cnt == 16'hFFFF)
                    err_q <= 1'b1;
                beat_cnt <= beat_cnt + 16'd1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
